// File: rtl/twos_to_sign_magnitude_serial_if.sv
`default_nettype none
// ============================================================================
// Module      : twos_to_sign_magnitude_serial_if
// Description : Valid/ready handshake bundle for the bit-serial two's-complement
//               to sign-magnitude converter (input channel and result channel).
// Revision    : 1.0 - initial release
// ============================================================================
interface twos_to_sign_magnitude_serial_if #(
    parameter int N = 8
);
    // Input channel
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   in_data;

    // Result channel
    logic           out_valid;
    logic           out_ready;
    logic           out_sign;
    logic [N-1:0]   out_mag;
    logic           out_overflow;

    // Producer of operands / consumer of results
    modport master (
        output in_valid,
        input  in_ready,
        output in_data,
        input  out_valid,
        output out_ready,
        input  out_sign,
        input  out_mag,
        input  out_overflow
    );

    // The converter itself
    modport slave (
        input  in_valid,
        output in_ready,
        input  in_data,
        output out_valid,
        input  out_ready,
        output out_sign,
        output out_mag,
        output out_overflow
    );
endinterface
`default_nettype wire

// File: rtl/twos_to_sign_magnitude_serial.sv
`default_nettype none
// ============================================================================
// Module      : twos_to_sign_magnitude_serial
// Description : Bit-serial N-bit two's-complement to sign-magnitude converter.
//               Negative operands are negated LSB first through one half-adder
//               stage (invert bit, add registered carry), one bit per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module twos_to_sign_magnitude_serial #(
    parameter int N = 8
) (
    input  wire logic                            clk,
    input  wire logic                            rst_n,
    twos_to_sign_magnitude_serial_if.slave       bus
);

    localparam int             CW          = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]  C_CNT_LAST  = CW'(N - 1);
    localparam logic [N-1:0]   C_MOST_NEG  = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [N-1:0]    r_d;          // operand, shifted right one bit per cycle
    logic [N-1:0]    r_m;          // magnitude being assembled from the MSB end
    logic [CW-1:0]   r_cnt;
    logic            r_carry;
    logic            r_sign;
    logic            r_out_valid;
    logic            r_out_sign;
    logic [N-1:0]    r_out_mag;
    logic            r_out_overflow;

    logic            w_b;
    logic            w_m;
    logic            w_carry_nxt;
    logic [N-1:0]    w_m_nxt;

    // One serial negation step: ~b + carry for negatives, pass-through otherwise
    always_comb begin
        w_b         = r_d[0];
        w_m         = r_sign ? (~w_b ^ r_carry) : w_b;
        w_carry_nxt = r_sign ? (~w_b & r_carry) : r_carry;
        w_m_nxt     = {w_m, r_m[N-1:1]};
    end

    // Control FSM with registered datapath and registered result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_d            <= '0;
            r_m            <= '0;
            r_cnt          <= '0;
            r_carry        <= 1'b0;
            r_sign         <= 1'b0;
            r_out_valid    <= 1'b0;
            r_out_sign     <= 1'b0;
            r_out_mag      <= '0;
            r_out_overflow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_d     <= bus.in_data;
                        r_sign  <= bus.in_data[N-1];
                        r_cnt   <= '0;
                        r_carry <= 1'b1;
                        r_m     <= '0;
                        r_state <= S_CONV;
                    end
                end
                S_CONV: begin
                    r_m     <= w_m_nxt;
                    r_d     <= {1'b0, r_d[N-1:1]};
                    r_carry <= w_carry_nxt;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == C_CNT_LAST) begin
                        // Final carry is dropped: it is only 1 for a zero
                        // operand, which never takes the negate path.
                        r_out_mag      <= w_m_nxt;
                        r_out_sign     <= r_sign;
                        r_out_overflow <= r_sign & (w_m_nxt == C_MOST_NEG);
                        r_out_valid    <= 1'b1;
                        r_state        <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready     = (r_state == S_IDLE);
    assign bus.out_valid    = r_out_valid;
    assign bus.out_sign     = r_out_sign;
    assign bus.out_mag      = r_out_mag;
    assign bus.out_overflow = r_out_overflow;

endmodule
`default_nettype wire

// File: tb/tb_twos_to_sign_magnitude_serial.sv
`default_nettype none
// ============================================================================
// Module      : tb_twos_to_sign_magnitude_serial
// Description : Directed self-checking bench for the serial two's-complement
//               to sign-magnitude converter (N=8 instance plus an N=4 instance).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_twos_to_sign_magnitude_serial;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   cyc;
    int   last_accept;

    twos_to_sign_magnitude_serial_if #(.N(8)) bus8 ();
    twos_to_sign_magnitude_serial_if #(.N(4)) bus4 ();

    twos_to_sign_magnitude_serial #(.N(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8.slave)
    );

    twos_to_sign_magnitude_serial #(.N(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single comparison point: counts every check, reports mismatches
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full N=8 transaction with out_ready assumed high; returns just after the
    // edge following the output handshake.
    task automatic conv8(input logic [7:0] x, input logic exp_sign,
                         input logic [7:0] exp_mag, input logic exp_ovf,
                         input int exp_gap);
        int n;
        check_val("in_ready_before", bus8.in_ready, 1);
        bus8.in_valid = 1'b1;
        bus8.in_data  = x;
        @(posedge clk);
        if (exp_gap > 0) check_val("issue_gap", cyc - last_accept, exp_gap);
        last_accept = cyc;
        #1;
        bus8.in_valid = 1'b0;
        n = 0;
        while (!bus8.out_valid && n < 20) begin
            step();
            n++;
        end
        check_val("latency", n, 8);
        check_val("sign", bus8.out_sign, exp_sign);
        check_val("mag", bus8.out_mag, exp_mag);
        check_val("ovf", bus8.out_overflow, exp_ovf);
        step();
        check_val("valid_drop", bus8.out_valid, 0);
        check_val("in_ready_after", bus8.in_ready, 1);
    endtask

    task automatic conv4(input logic [3:0] x, input logic exp_sign,
                         input logic [3:0] exp_mag, input logic exp_ovf);
        int n;
        check_val("n4_in_ready", bus4.in_ready, 1);
        bus4.in_valid = 1'b1;
        bus4.in_data  = x;
        step();
        bus4.in_valid = 1'b0;
        n = 0;
        while (!bus4.out_valid && n < 20) begin
            step();
            n++;
        end
        check_val("n4_latency", n, 4);
        check_val("n4_sign", bus4.out_sign, exp_sign);
        check_val("n4_mag", bus4.out_mag, exp_mag);
        check_val("n4_ovf", bus4.out_overflow, exp_ovf);
        step();
        check_val("n4_valid_drop", bus4.out_valid, 0);
    endtask

    initial begin
        logic [7:0] x;
        logic [7:0] neg;
        int n;
        n_checks = 0;
        n_fail = 0;
        cyc = 0;
        last_accept = 0;
        bus8.in_valid = 1'b0; bus8.in_data = '0; bus8.out_ready = 1'b1;
        bus4.in_valid = 1'b0; bus4.in_data = '0; bus4.out_ready = 1'b1;

        // Reset held for 3 cycles
        rst_n = 1'b0;
        repeat (3) step();
        check_val("rst_valid", bus8.out_valid, 0);
        check_val("rst_sign", bus8.out_sign, 0);
        check_val("rst_mag", bus8.out_mag, 0);
        check_val("rst_ovf", bus8.out_overflow, 0);
        rst_n = 1'b1;
        step();
        check_val("rst_in_ready", bus8.in_ready, 1);

        // Zero, positives, negatives, most negative
        conv8(8'h00, 1'b0, 8'h00, 1'b0, 0);
        conv8(8'h7F, 1'b0, 8'h7F, 1'b0, 0);
        conv8(8'hFF, 1'b1, 8'h01, 1'b0, 0);
        conv8(8'hA6, 1'b1, 8'h5A, 1'b0, 0);
        conv8(8'h80, 1'b1, 8'h80, 1'b1, 0);

        // Backpressure: result must hold, in_ready low, stray input ignored
        bus8.out_ready = 1'b0;
        bus8.in_valid = 1'b1;
        bus8.in_data  = 8'hF0;
        step();
        bus8.in_valid = 1'b0;
        n = 0;
        while (!bus8.out_valid && n < 20) begin
            step();
            n++;
        end
        check_val("bp_latency", n, 8);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                bus8.in_valid = 1'b1;
                bus8.in_data  = 8'h33;
            end else begin
                bus8.in_valid = 1'b0;
            end
            step();
            check_val("bp_valid", bus8.out_valid, 1);
            check_val("bp_sign", bus8.out_sign, 1);
            check_val("bp_mag", bus8.out_mag, 8'h10);
            check_val("bp_in_ready", bus8.in_ready, 0);
        end
        bus8.in_valid = 1'b0;
        bus8.out_ready = 1'b1;
        step();
        check_val("bp_release", bus8.out_valid, 0);
        check_val("bp_mag_kept", bus8.out_mag, 8'h10);
        for (int i = 0; i < 10; i++) step();
        check_val("bp_no_capture", bus8.out_valid, 0);
        check_val("bp_idle", bus8.in_ready, 1);

        // Reset in the middle of a conversion discards it
        bus8.in_valid = 1'b1;
        bus8.in_data  = 8'h81;
        step();
        bus8.in_valid = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        #2;
        check_val("mid_rst_valid", bus8.out_valid, 0);
        step();
        step();
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus8.out_valid) n++;
        end
        check_val("mid_rst_no_out", n, 0);
        conv8(8'h05, 1'b0, 8'h05, 1'b0, 0);

        // Exhaustive sweep, back-to-back at N+2 spacing
        for (int v = 0; v < 256; v++) begin
            x   = 8'(v);
            neg = ~x + 8'd1;
            conv8(x, x[7], x[7] ? neg : x, (x == 8'h80), (v == 0) ? 0 : 10);
        end

        // N=4 spot checks
        conv4(4'h8, 1'b1, 4'h8, 1'b1);
        conv4(4'hD, 1'b1, 4'h3, 1'b0);
        conv4(4'h5, 1'b0, 4'h5, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
